// File: rtl/gru_pkg.sv
// Shared GRU definitions: Q4.12 word geometry, fixed-point constants and the
// pre-activation MAC state encoding.
package gru_pkg;

  localparam int GRU_N  = 16;
  localparam int GRU_Q  = 12;
  localparam int GRU_AW = 10;

  localparam logic [GRU_N-1:0] ONE = 16'h1000;
  localparam logic [GRU_N-1:0] MAX = 16'h7FFF;
  localparam logic [GRU_N-1:0] MIN = 16'h8000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage : gru_pkg

// File: rtl/gate_preact_mac_qsat.sv
// Rescales a wide Q.2Q accumulator to Q, adds the gate bias and clamps the sum
// to the signed N-bit range, flagging when the clamp engaged.
module qsat #(
  parameter int N    = gru_pkg::GRU_N,
  parameter int Q    = gru_pkg::GRU_Q,
  parameter int ACCW = 2 * gru_pkg::GRU_N + 4
) (
  input  logic signed [ACCW-1:0] i_acc,
  input  logic signed [N-1:0]    i_bias,
  output logic        [N-1:0]    o_result,
  output logic                   o_sat
);

  localparam logic signed [ACCW-1:0] LIM_MAX =
    signed'({{(ACCW-N+1){1'b0}}, {(N-1){1'b1}}});
  localparam logic signed [ACCW-1:0] LIM_MIN =
    signed'({{(ACCW-N+1){1'b1}}, {(N-1){1'b0}}});

  logic signed [ACCW-1:0] w_shifted;
  logic signed [ACCW-1:0] w_bias_ext;
  logic signed [ACCW-1:0] w_sum;

  // Arithmetic shift floors toward minus infinity; the sum cannot wrap because
  // the shifted value leaves Q bits of headroom in ACCW.
  assign w_shifted  = i_acc >>> Q;
  assign w_bias_ext = {{(ACCW-N){i_bias[N-1]}}, i_bias};
  assign w_sum      = w_shifted + w_bias_ext;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the branches can infer a latch.
  always_comb begin
    o_result = w_sum[N-1:0];
    o_sat    = 1'b0;
    if (w_sum > LIM_MAX) begin
      o_result = LIM_MAX[N-1:0];
      o_sat    = 1'b1;
    end else if (w_sum < LIM_MIN) begin
      o_result = LIM_MIN[N-1:0];
      o_sat    = 1'b1;
    end
  end

endmodule : qsat

// File: rtl/gate_preact_mac.sv
// GRU gate pre-activation: accumulates LEN x*w products, rescales, adds bias,
// saturates and presents the result plus its sigmoid/tanh LUT index.
module gate_preact_mac
  import gru_pkg::*;
#(
  parameter int N   = GRU_N,
  parameter int Q   = GRU_Q,
  parameter int AW  = GRU_AW,
  parameter int LEN = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  bias,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  x_data,
  input  logic [N-1:0]  w_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  preact,
  output logic [AW-1:0] lut_addr,
  output logic          sat,
  output logic          busy
);

  localparam int CNTW = $clog2(LEN + 1);
  localparam int ACCW = 2 * N + $clog2(LEN) + 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(LEN - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic signed [ACCW-1:0] r_acc;
  logic        [CNTW-1:0] r_cnt;
  logic signed [N-1:0]    r_bias;
  logic        [N-1:0]    r_preact;
  logic                   r_sat;

  logic signed [N-1:0]    w_x;
  logic signed [N-1:0]    w_w;
  logic signed [2*N-1:0]  w_prod;
  logic signed [ACCW-1:0] w_acc_next;
  logic                   w_beat;
  logic                   w_last;
  logic        [N-1:0]    w_result;
  logic                   w_sat;

  assign w_x        = signed'(x_data);
  assign w_w        = signed'(w_data);
  assign w_prod     = w_x * w_w;
  assign w_acc_next = r_acc + {{(ACCW-2*N){w_prod[2*N-1]}}, w_prod};
  assign w_beat     = in_valid && (r_state == S_ACCUM);
  assign w_last     = w_beat && (r_cnt == LAST_CNT);

  // The final beat's product is folded in combinationally so the registered
  // result is ready the cycle DONE is entered.
  qsat #(
    .N    (N),
    .Q    (Q),
    .ACCW (ACCW)
  ) u_qsat (
    .i_acc    (w_acc_next),
    .i_bias   (r_bias),
    .o_result (w_result),
    .o_sat    (w_sat)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)     w_state_next = S_ACCUM;
      S_ACCUM: if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_bias   <= '0;
      r_preact <= '0;
      r_sat    <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_bias <= signed'(bias);
        r_acc  <= '0;
        r_cnt  <= '0;
      end else if (w_beat) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_preact <= w_result;
          r_sat    <= w_sat;
        end
      end
    end
  end

  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign preact    = r_preact;
  assign lut_addr  = r_preact[N-1:N-AW];
  assign sat       = r_sat;

endmodule : gate_preact_mac

// File: tb/tb_gate_preact_mac.sv
// Directed bench for gate_preact_mac: hand-computed Q4.12 vectors, output
// hold under backpressure, mid-sequence reset and randomly gapped input.
module tb_gate_preact_mac;
  import gru_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bias = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x_data = '0;
  logic [15:0] w_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] preact;
  logic [9:0]  lut_addr;
  logic        sat;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gate_preact_mac #(.N(16), .Q(12), .AW(10), .LEN(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_data    (x_data),
    .w_data    (w_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .preact    (preact),
    .lut_addr  (lut_addr),
    .sat       (sat),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {in_ready, out_valid, preact, lut_addr, sat, busy}, 32'h0);
  endtask

  // Starts a sequence and feeds 8 beats; returns at the negedge after the
  // 8th accepted beat, where out_valid must already be high.
  task automatic run_seq(input string tag, input logic [15:0] b, input logic [15:0] x,
                         input logic [15:0] w, input bit gaps);
    int sent = 0;
    int cycles = 0;
    bit early = 1'b0;
    logic v;
    @(negedge clk);
    start = 1'b1;
    bias  = b;
    @(negedge clk);
    start = 1'b0;
    x_data = x;
    w_data = w;
    while (sent < 8 && cycles < 200) begin
      if (out_valid) early = 1'b1;
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      if (v && in_ready) sent++;
      cycles++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({tag, "_beats"}, 32'(sent), 32'd8);
    check({tag, "_no_early_valid"}, 32'(early), 32'd0);
    check({tag, "_valid_lat1"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_after_hs"}, {30'd0, out_valid, busy}, 32'd0);
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // 8 * (1.0 * 0.5) = 4.0
    run_seq("basic", 16'h0000, 16'h1000, 16'h0800, 1'b0);
    check("basic_preact", {16'd0, preact}, 32'h4000);
    check("basic_lut", {22'd0, lut_addr}, 32'h100);
    check("basic_sat", {31'd0, sat}, 32'd0);
    check("basic_in_ready_done", {31'd0, in_ready}, 32'd0);
    drain("basic");

    // 8 * 7.0 * 7.0 = 392.0 saturates high
    run_seq("pos_sat", 16'h0000, 16'h7000, 16'h7000, 1'b0);
    check("pos_sat_preact", {16'd0, preact}, 32'h7FFF);
    check("pos_sat_lut", {22'd0, lut_addr}, 32'h1FF);
    check("pos_sat_flag", {31'd0, sat}, 32'd1);
    drain("pos_sat");

    // 8 * (-1.0) = -8.0 sits exactly on the minimum, no clamp
    run_seq("neg_edge", 16'h0000, 16'hF000, 16'h1000, 1'b0);
    check("neg_edge_preact", {16'd0, preact}, 32'h8000);
    check("neg_edge_lut", {22'd0, lut_addr}, 32'h200);
    check("neg_edge_sat", {31'd0, sat}, 32'd0);
    drain("neg_edge");

    // -8.0 + 0.5 = -7.5
    run_seq("neg_bias", 16'h0800, 16'hF000, 16'h1000, 1'b0);
    check("neg_bias_preact", {16'd0, preact}, 32'h8800);
    check("neg_bias_lut", {22'd0, lut_addr}, 32'h220);
    check("neg_bias_sat", {31'd0, sat}, 32'd0);

    // Backpressure: result held for 5 cycles, then start during handshake ignored
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_state", {13'd0, out_valid, in_ready, busy, preact}, {13'd0, 3'b101, 16'h8800});
    end
    out_ready = 1'b1;
    start     = 1'b1;
    bias      = 16'h1234;
    @(negedge clk);
    out_ready = 1'b0;
    check("hs_start_ignored", {30'd0, out_valid, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("idle_start_accepted", {31'd0, busy}, 32'd1);
    check("accum_in_ready", {31'd0, in_ready}, 32'd1);
    // Abandon that sequence with a reset after 3 beats
    x_data   = 16'h1000;
    w_data   = 16'h1000;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_quiet", {30'd0, out_valid, busy}, 32'd0);
    end
    run_seq("after_rst", 16'h0000, 16'h1000, 16'h0800, 1'b0);
    check("after_rst_preact", {16'd0, preact}, 32'h4000);
    drain("after_rst");

    // Gapped input must produce the same result
    run_seq("gaps", 16'h0000, 16'h1000, 16'h0800, 1'b1);
    check("gaps_preact", {16'd0, preact}, 32'h4000);
    check("gaps_lut", {22'd0, lut_addr}, 32'h100);
    drain("gaps");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_gate_preact_mac
